// File: rtl/tholin_bus_pkg.sv
// Shared types and constants for the tholin external-memory bus controller.
// Pulled in by the controller with an import of tholin_bus_pkg.
package tholin_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AHI  = 3'd1,
        ST_ALO  = 3'd2,
        ST_DATA = 3'd3,
        ST_TURN = 3'd4,
        ST_DONE = 3'd5
    } bus_state_t;

    localparam logic BUS_DIR_IN = 1'b1;
    localparam int   HI_ADDR_W  = 15;

    // Halfword address presented during the ALO phase.
    function automatic logic [15:0] lo_addr(input logic [14:0] word_addr, input logic hw);
        return {word_addr, hw};
    endfunction

endpackage

// File: rtl/tholin_bus_ctrl.sv
// Sequences 32-bit word requests onto the 16-bit multiplexed pad bus.
// Every pad output is a flop loaded from the state being entered.
module tholin_bus_ctrl
    import tholin_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [15:0] bus_out,
    input  logic [15:0] bus_in,
    output logic        le_hi,
    output logic        le_lo,
    output logic        bus_dir,
    output logic        OEb,
    output logic        WEb_lo,
    output logic        WEb_hi
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    bus_state_t             state_q, state_d;
    logic                   hw_q, hw_d;
    logic                   we_q, we_d;
    logic [31:2]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic                   hi_valid_q, hi_valid_d;
    logic [HI_ADDR_W-1:0]   hi_q, hi_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            rbuf_q, rbuf_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic [15:0]            bus_out_q, bus_out_d;
    logic                   le_hi_q, le_hi_d;
    logic                   le_lo_q, le_lo_d;
    logic                   bus_dir_q, bus_dir_d;
    logic                   oeb_q, oeb_d;
    logic                   web_lo_q, web_lo_d;
    logic                   web_hi_q, web_hi_d;

    logic                   accept_s;
    logic                   more_s;
    logic                   last_wait_s;
    logic [31:2]            addr_s;
    logic [31:0]            wdata_s;
    logic [3:0]             be_s;
    logic                   we_s;
    logic                   unused_addr_s;

    assign unused_addr_s = ^addr[1:0];

    assign accept_s    = (state_q == ST_IDLE) && req && !busy_q;
    assign more_s      = (hw_q == 1'b0) && (be_q[3:2] != 2'b00);
    assign last_wait_s = (cnt_q == CNT_W'(1));
    assign addr_s      = accept_s ? addr[31:2] : addr_q;
    assign wdata_s     = accept_s ? wdata      : wdata_q;
    assign be_s        = accept_s ? be         : be_q;
    assign we_s        = accept_s ? we         : we_q;

    // Next state, request capture, hi-address cache and read assembly.
    always_comb begin
        state_d    = state_q;
        hw_d       = hw_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        hi_valid_d = hi_valid_q;
        hi_d       = hi_q;
        rbuf_d     = rbuf_q;
        rdata_d    = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    we_d    = we;
                    addr_d  = addr[31:2];
                    wdata_d = wdata;
                    be_d    = be;
                    rbuf_d  = 32'h0000_0000;
                    hw_d    = (be[1:0] == 2'b00);
                    // An empty request idles one cycle in TURN so ack lands one edge later.
                    if (be == 4'b0000) begin
                        state_d = ST_TURN;
                    end else if (hi_valid_q && (hi_q == addr[31:17])) begin
                        state_d = ST_ALO;
                    end else begin
                        state_d = ST_AHI;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AHI:  state_d = ST_ALO;
            ST_ALO:  state_d = ST_DATA;
            ST_DATA: begin
                if (last_wait_s) begin
                    if (!we_q) begin
                        state_d = ST_TURN;
                        if (hw_q) begin
                            rbuf_d[31:16] = bus_in;
                        end else begin
                            rbuf_d[15:0] = bus_in;
                        end
                    end else if (more_s) begin
                        state_d = ST_ALO;
                        hw_d    = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_TURN: begin
                if (more_s) begin
                    state_d = ST_ALO;
                    hw_d    = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_AHI) begin
            hi_valid_d = 1'b1;
            hi_d       = addr_s[31:17];
        end else begin
            hi_valid_d = hi_valid_q;
        end

        if ((state_d == ST_DONE) && !we_q) begin
            rdata_d = rbuf_q;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Wait counter: reloaded on entry to DATA, counts down while there.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == ST_DATA) && (state_q != ST_DATA)) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end else if (state_q == ST_DATA) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pad and handshake outputs for the state being entered.
    always_comb begin
        bus_out_d = bus_out_q;
        le_hi_d   = 1'b0;
        le_lo_d   = 1'b0;
        bus_dir_d = BUS_DIR_IN;
        oeb_d     = 1'b1;
        web_lo_d  = 1'b1;
        web_hi_d  = 1'b1;
        ack_d     = 1'b0;
        busy_d    = (state_d != ST_IDLE);

        case (state_d)
            ST_AHI: begin
                bus_dir_d = ~BUS_DIR_IN;
                bus_out_d = {1'b0, addr_s[31:17]};
                le_hi_d   = 1'b1;
            end
            ST_ALO: begin
                bus_dir_d = ~BUS_DIR_IN;
                bus_out_d = lo_addr(addr_s[16:2], hw_d);
                le_lo_d   = 1'b1;
            end
            ST_DATA: begin
                if (we_s) begin
                    bus_dir_d = ~BUS_DIR_IN;
                    bus_out_d = hw_d ? wdata_s[31:16] : wdata_s[15:0];
                    web_lo_d  = hw_d ? ~be_s[2] : ~be_s[0];
                    web_hi_d  = hw_d ? ~be_s[3] : ~be_s[1];
                end else begin
                    bus_dir_d = BUS_DIR_IN;
                    oeb_d     = 1'b0;
                end
            end
            ST_DONE: ack_d = 1'b1;
            default: ack_d = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hw_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 30'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            be_q       <= 4'b0000;
            hi_valid_q <= 1'b0;
            hi_q       <= 15'h0000;
            cnt_q      <= '0;
            rbuf_q     <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            bus_out_q  <= 16'h0000;
            le_hi_q    <= 1'b0;
            le_lo_q    <= 1'b0;
            bus_dir_q  <= BUS_DIR_IN;
            oeb_q      <= 1'b1;
            web_lo_q   <= 1'b1;
            web_hi_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            hw_q       <= hw_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            hi_valid_q <= hi_valid_d;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
            rbuf_q     <= rbuf_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            bus_out_q  <= bus_out_d;
            le_hi_q    <= le_hi_d;
            le_lo_q    <= le_lo_d;
            bus_dir_q  <= bus_dir_d;
            oeb_q      <= oeb_d;
            web_lo_q   <= web_lo_d;
            web_hi_q   <= web_hi_d;
        end
    end

    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign bus_out = bus_out_q;
    assign le_hi   = le_hi_q;
    assign le_lo   = le_lo_q;
    assign bus_dir = bus_dir_q;
    assign OEb     = oeb_q;
    assign WEb_lo  = web_lo_q;
    assign WEb_hi  = web_hi_q;

endmodule

// File: tb/tb_tholin_bus_ctrl.sv
// Directed bench for tholin_bus_ctrl: one instance with WAIT_CYCLES=1 and one with 3,
// each with a small pad-side memory model that latches the lo address.
module tb_tholin_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack, busy, le_hi, le_lo, bus_dir, oeb, web_lo, web_hi;
    logic [31:0] rdata;
    logic [15:0] bus_out, bus_in;

    logic        req3, we3;
    logic [31:0] addr3, wdata3;
    logic [3:0]  be3;
    logic        ack3, busy3, le_hi3, le_lo3, bus_dir3, oeb3, web_lo3, web_hi3;
    logic [31:0] rdata3;
    logic [15:0] bus_out3, bus_in3;

    int checks = 0;
    int failures = 0;

    tholin_bus_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack), .rdata(rdata), .busy(busy), .bus_out(bus_out), .bus_in(bus_in),
        .le_hi(le_hi), .le_lo(le_lo), .bus_dir(bus_dir), .OEb(oeb),
        .WEb_lo(web_lo), .WEb_hi(web_hi)
    );

    tholin_bus_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3), .be(be3),
        .ack(ack3), .rdata(rdata3), .busy(busy3), .bus_out(bus_out3), .bus_in(bus_in3),
        .le_hi(le_hi3), .le_lo(le_lo3), .bus_dir(bus_dir3), .OEb(oeb3),
        .WEb_lo(web_lo3), .WEb_hi(web_hi3)
    );

    function automatic logic [15:0] mem_rd(input logic [15:0] lo);
        case (lo)
            16'h0002: return 16'hBEEF;
            16'h0003: return 16'hDEAD;
            16'h0004: return 16'hCAFE;
            16'h0005: return 16'hF00D;
            default:  return 16'h0000;
        endcase
    endfunction

    // Pad-side memory: lo address latched while le_lo is high.
    logic [15:0] lo_lat = 16'h0000, lo_lat3 = 16'h0000;
    int n_lehi = 0, n_lelo = 0, n_oe = 0, n_we = 0;
    int n_oe3 = 0, oe3_run = 0, oe3_max = 0;

    always @(negedge clk) begin
        if (le_lo) lo_lat <= bus_out;
        if (le_lo3) lo_lat3 <= bus_out3;
        if (le_hi) n_lehi <= n_lehi + 1;
        if (le_lo) n_lelo <= n_lelo + 1;
        if (!oeb) n_oe <= n_oe + 1;
        if (!web_lo || !web_hi) n_we <= n_we + 1;
        if (!oeb3) n_oe3 <= n_oe3 + 1;
        oe3_run <= oeb3 ? 0 : oe3_run + 1;
        if (!oeb3 && (oe3_run + 1 > oe3_max)) oe3_max <= oe3_run + 1;
    end

    assign bus_in  = oeb ? 16'h0000 : mem_rd(lo_lat);
    // Valid data only in the third OEb-low cycle, so an early capture reads 0BAD.
    assign bus_in3 = (oe3_run == 3) ? mem_rd(lo_lat3) : 16'h0BAD;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
    endtask

    // Counts edges after E0 until ack is seen; returns 40 on timeout.
    task automatic wait_ack(input bit sel3, output int e);
        e = 0;
        while (!(sel3 ? ack3 : ack) && e < 40) begin
            step();
            e++;
        end
    endtask

    int e;
    int s_lehi, s_lelo, s_oe, s_we;

    initial begin
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
        req3 = 1'b0; we3 = 1'b0; addr3 = 32'h0; wdata3 = 32'h0; be3 = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_bus_out", {16'h0, bus_out}, 32'h0);
        chk("rst_le", {30'h0, le_hi, le_lo}, 32'h0);
        chk("rst_dir_oe_we", {28'h0, bus_dir, oeb, web_lo, web_hi}, 32'hF);
        chk("rst_ack_busy", {30'h0, ack, busy}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        step();

        // Read miss, WAIT_CYCLES=1
        issue(1'b0, 32'h0002_0004, 32'h0, 4'hF);
        step();
        chk("rd1_ahi", {14'h0, le_hi, bus_dir, bus_out}, {14'h0, 1'b1, 1'b0, 16'h0001});
        chk("rd1_busy", {31'h0, busy}, 32'h1);
        step();
        chk("rd1_alo0", {14'h0, le_lo, le_hi, bus_out}, {14'h0, 1'b1, 1'b0, 16'h0002});
        step();
        chk("rd1_data0", {30'h0, oeb, bus_dir}, {30'h0, 1'b0, 1'b1});
        step();
        chk("rd1_turn0", {29'h0, oeb, bus_dir, ack}, {29'h0, 1'b1, 1'b1, 1'b0});
        step();
        chk("rd1_alo1", {15'h0, le_lo, bus_out}, {15'h0, 1'b1, 16'h0003});
        step();
        chk("rd1_data1", {31'h0, oeb}, 32'h0);
        step();
        chk("rd1_turn1", {29'h0, oeb, bus_dir, ack}, {29'h0, 1'b1, 1'b1, 1'b0});
        step();
        chk("rd1_ack_e7", {31'h0, ack}, 32'h1);
        chk("rd1_rdata", rdata, 32'hDEAD_BEEF);
        req = 1'b0;
        step();
        chk("rd1_ack_pulse", {30'h0, ack, busy}, 32'h0);

        // Read hit: AHI skipped
        s_lehi = n_lehi;
        issue(1'b0, 32'h0002_0008, 32'h0, 4'hF);
        step();
        wait_ack(1'b0, e);
        chk("rd2_ack_edge", e, 6);
        chk("rd2_rdata", rdata, 32'hF00D_CAFE);
        chk("rd2_no_ahi", n_lehi - s_lehi, 0);
        req = 1'b0;
        step();

        // Single-byte write on halfword 1, cache miss
        issue(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0100);
        step();
        chk("wr_ahi", {15'h0, le_hi, bus_out}, {15'h0, 1'b1, 16'h0000});
        step();
        chk("wr_alo", {15'h0, le_lo, bus_out}, {15'h0, 1'b1, 16'h0009});
        step();
        chk("wr_data", {13'h0, bus_dir, web_lo, web_hi, bus_out}, {13'h0, 1'b0, 1'b0, 1'b1, 16'h1234});
        chk("wr_data_ack", {31'h0, ack}, 32'h0);
        step();
        chk("wr_ack_e3", {31'h0, ack}, 32'h1);
        chk("wr_web_idle", {30'h0, web_lo, web_hi}, 32'h3);
        req = 1'b0;
        step();
        chk("wr_rdata_held", rdata, 32'hF00D_CAFE);

        // Empty request
        s_lehi = n_lehi; s_lelo = n_lelo; s_oe = n_oe; s_we = n_we;
        issue(1'b1, 32'h0002_0004, 32'hFFFF_FFFF, 4'b0000);
        step();
        chk("be0_e0", {30'h0, ack, busy}, {30'h0, 1'b0, 1'b1});
        step();
        chk("be0_ack_e1", {31'h0, ack}, 32'h1);
        chk("be0_no_pads", (n_lehi - s_lehi) + (n_lelo - s_lelo) + (n_oe - s_oe) + (n_we - s_we), 0);
        req = 1'b0;
        step();

        // WAIT_CYCLES=3 read
        req3 = 1'b1; we3 = 1'b0; addr3 = 32'h0002_0004; be3 = 4'hF;
        step();
        wait_ack(1'b1, e);
        chk("w3_ack_edge", e, 11);
        chk("w3_rdata", rdata3, 32'hDEAD_BEEF);
        chk("w3_oe_cycles", n_oe3, 6);
        chk("w3_oe_run", oe3_max, 3);
        req3 = 1'b0;
        step();

        // Reset during read DATA
        issue(1'b0, 32'h0002_0004, 32'h0, 4'hF);
        step();
        chk("rr_ahi", {31'h0, le_hi}, 32'h1);
        step();
        step();
        chk("rr_in_data", {31'h0, oeb}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rr_async_pads", {26'h0, bus_dir, oeb, web_lo, web_hi, le_hi, le_lo}, {26'h0, 6'b111100});
        chk("rr_async_ctl", {30'h0, ack, busy}, 32'h0);
        chk("rr_async_bus", {16'h0, bus_out}, 32'h0);
        chk("rr_async_rdata", rdata, 32'h0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        issue(1'b0, 32'h0002_0004, 32'h0, 4'hF);
        step();
        chk("rr_ahi_rerun", {15'h0, le_hi, bus_out}, {15'h0, 1'b1, 16'h0001});
        wait_ack(1'b0, e);
        chk("rr_ack_edge", e, 7);
        chk("rr_rdata", rdata, 32'hDEAD_BEEF);
        req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
